// File: rtl/as2650_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | as2650_pkg : bus-sequencer state encoding and shared bus-phase constants |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package as2650_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR_HI = 3'd1,
      ST_ADDR_LO = 3'd2,
      ST_READ    = 3'd3,
      ST_WRITE   = 3'd4
   } bus_state_t;

   localparam int          WAIT_W     = 3;
   localparam logic [7:0]  BUS_PARK   = 8'h00;
   localparam logic [15:0] RESET_ADDR = 16'h0000;

   function automatic logic is_strobe_state(input bus_state_t s);
      return (s == ST_READ) || (s == ST_WRITE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/as2650_strobe_halfcyc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | as2650_strobe_halfcyc : latch enable high for the first half-cycle only  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module as2650_strobe_halfcyc #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic enter,
   output logic le
);

   logic armed;
   logic done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) armed <= RESET_VAL;
      else     armed <= enter;
   end

   // done trails armed by half a cycle, closing the window at the falling edge
   always_ff @(negedge clk or posedge rst) begin
      if (rst) done <= 1'b0;
      else     done <= armed;
   end

   assign le = armed & ~done & ~rst;

endmodule
`default_nettype wire

// File: rtl/as2650_bus_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | as2650_bus_sequencer : core requests -> multiplexed 8-bit external bus   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module as2650_bus_sequencer
   import as2650_pkg::*;
#(
   parameter int WAIT_STATES = 0,
   parameter int HI_CACHE    = 1
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        req,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   output logic        ready,
   output logic [7:0]  rdata,
   output logic [7:0]  bus_out,
   output logic        bus_oe,
   input  logic [7:0]  bus_in,
   output logic        le_hi,
   output logic        le_lo,
   output logic        oe_n,
   output logic        we_n
);

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_STATES);

   bus_state_t        state;
   bus_state_t        state_next;
   logic [15:0]       addr_q;
   logic              we_q;
   logic [7:0]        wdata_q;
   logic [7:0]        hi_held;
   logic              hi_valid;
   logic [WAIT_W-1:0] wait_cnt;
   logic              last;
   logic              hi_hit;
   logic              enter_hi;
   logic              enter_lo;

   assign last     = (wait_cnt == WAIT_LAST);
   assign hi_hit   = (HI_CACHE != 0) && hi_valid && (addr[15:8] == hi_held);
   assign enter_hi = (state_next == ST_ADDR_HI);
   assign enter_lo = (state_next == ST_ADDR_LO);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state <= ST_ADDR_HI;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      bus_out    = BUS_PARK;
      bus_oe     = 1'b1;
      oe_n       = 1'b1;
      we_n       = 1'b1;
      case (state)
         ST_IDLE: begin
            if (req) state_next = hi_hit ? ST_ADDR_LO : ST_ADDR_HI;
         end
         ST_ADDR_HI: begin
            bus_out    = addr_q[15:8];
            state_next = ST_ADDR_LO;
         end
         ST_ADDR_LO: begin
            bus_out    = addr_q[7:0];
            state_next = we_q ? ST_WRITE : ST_READ;
         end
         ST_READ: begin
            oe_n   = 1'b0;
            bus_oe = 1'b0;
            if (last) state_next = ST_IDLE;
         end
         ST_WRITE: begin
            we_n    = 1'b0;
            bus_out = wdata_q;
            if (last) state_next = ST_IDLE;
         end
         default: state_next = ST_ADDR_HI;
      endcase
   end

   // Reset leaves a read of RESET_ADDR pending so the core's first fetch starts at once
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         addr_q   <= RESET_ADDR;
         we_q     <= 1'b0;
         wdata_q  <= 8'h00;
         hi_held  <= 8'h00;
         hi_valid <= 1'b0;
         wait_cnt <= '0;
         rdata    <= 8'h00;
         ready    <= 1'b0;
      end else begin
         ready <= 1'b0;
         if (state == ST_IDLE && req) begin
            addr_q  <= addr;
            we_q    <= we;
            wdata_q <= wdata;
         end
         if (state == ST_ADDR_HI) begin
            hi_held  <= addr_q[15:8];
            hi_valid <= 1'b1;
         end
         if (is_strobe_state(state)) begin
            if (last) begin
               ready    <= 1'b1;
               wait_cnt <= '0;
               if (state == ST_READ) rdata <= bus_in;
            end else begin
               wait_cnt <= wait_cnt + 1'b1;
            end
         end
      end
   end

   as2650_strobe_halfcyc #(.RESET_VAL(1'b1)) u_le_hi (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .enter (enter_hi),
      .le    (le_hi)
   );

   as2650_strobe_halfcyc #(.RESET_VAL(1'b0)) u_le_lo (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .enter (enter_lo),
      .le    (le_lo)
   );

endmodule
`default_nettype wire

// File: tb/tb_as2650_bus_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_as2650_bus_sequencer : directed bench, zero- and two-wait-state DUTs  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_as2650_bus_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, we;
   logic [15:0] addr;
   logic [7:0]  wdata, bus_in;
   logic        ready, bus_oe, le_hi, le_lo, oe_n, we_n;
   logic [7:0]  rdata, bus_out;

   logic        req_2, we_2;
   logic [15:0] addr_2;
   logic [7:0]  wdata_2, bus_in_2;
   logic        ready_2, bus_oe_2, le_hi_2, le_lo_2, oe_n_2, we_n_2;
   logic [7:0]  rdata_2, bus_out_2;

   logic [7:0]  ext_hi = 8'h00;
   logic [7:0]  ext_lo = 8'h00;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   as2650_bus_sequencer #(.WAIT_STATES(0), .HI_CACHE(1)) dut (
      .wb_clk_i (clk),     .wb_rst_i (rst),
      .req      (req),     .we       (we),
      .addr     (addr),    .wdata    (wdata),
      .ready    (ready),   .rdata    (rdata),
      .bus_out  (bus_out), .bus_oe   (bus_oe),
      .bus_in   (bus_in),  .le_hi    (le_hi),
      .le_lo    (le_lo),   .oe_n     (oe_n),
      .we_n     (we_n)
   );

   as2650_bus_sequencer #(.WAIT_STATES(2), .HI_CACHE(1)) dut_ws2 (
      .wb_clk_i (clk),       .wb_rst_i (rst),
      .req      (req_2),     .we       (we_2),
      .addr     (addr_2),    .wdata    (wdata_2),
      .ready    (ready_2),   .rdata    (rdata_2),
      .bus_out  (bus_out_2), .bus_oe   (bus_oe_2),
      .bus_in   (bus_in_2),  .le_hi    (le_hi_2),
      .le_lo    (le_lo_2),   .oe_n     (oe_n_2),
      .we_n     (we_n_2)
   );

   // external address latches close on the falling enable
   always @(negedge le_hi) ext_hi = bus_out;
   always @(negedge le_lo) ext_lo = bus_out;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic half;
      @(negedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; req = 1'b1; we = 1'b0; addr = 16'h0000; wdata = 8'h00; bus_in = 8'h04;
      req_2 = 1'b0; we_2 = 1'b0; addr_2 = 16'h0000; wdata_2 = 8'h00; bus_in_2 = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_le_hi",   16'(le_hi),   16'h0);
      check("rst_le_lo",   16'(le_lo),   16'h0);
      check("rst_oe_n",    16'(oe_n),    16'h1);
      check("rst_we_n",    16'(we_n),    16'h1);
      check("rst_bus_oe",  16'(bus_oe),  16'h1);
      check("rst_bus_out", 16'(bus_out), 16'h00);
      check("rst_ready",   16'(ready),   16'h0);
      check("rst_rdata",   16'(rdata),   16'h00);

      // first fetch from 0x0000 straight out of reset
      cyc; rst = 1'b0; #1;
      check("f0_c1_le_hi",   16'(le_hi),   16'h1);
      check("f0_c1_bus_out", 16'(bus_out), 16'h00);
      half;
      check("f0_c1_le_hi_neg", 16'(le_hi), 16'h0);
      cyc;
      check("f0_c2_le_lo", 16'(le_lo), 16'h1);
      check("f0_c2_le_hi", 16'(le_hi), 16'h0);
      half;
      check("f0_c2_le_lo_neg", 16'(le_lo), 16'h0);
      cyc;
      check("f0_c3_oe_n",   16'(oe_n),   16'h0);
      check("f0_c3_bus_oe", 16'(bus_oe), 16'h0);
      check("f0_c3_ready",  16'(ready),  16'h0);
      cyc;
      check("f0_c4_ready", 16'(ready), 16'h1);
      check("f0_c4_rdata", 16'(rdata), 16'h04);
      check("f0_c4_oe_n",  16'(oe_n),  16'h1);

      // 0x0001: high byte cached
      addr = 16'h0001; bus_in = 8'h5A;
      cyc;
      check("r1_le_hi",   16'(le_hi),   16'h0);
      check("r1_le_lo",   16'(le_lo),   16'h1);
      check("r1_bus_out", 16'(bus_out), 16'h01);
      cyc;
      check("r1_oe_n",  16'(oe_n),  16'h0);
      check("r1_ready", 16'(ready), 16'h0);
      cyc;
      check("r1_ready_c3", 16'(ready), 16'h1);
      check("r1_rdata",    16'(rdata), 16'h5A);

      // write 0x0123 <- 0xC8
      we = 1'b1; addr = 16'h0123; wdata = 8'hC8;
      cyc;
      check("w_hi_le_hi",   16'(le_hi),   16'h1);
      check("w_hi_bus_out", 16'(bus_out), 16'h01);
      cyc;
      check("w_lo_le_lo",   16'(le_lo),   16'h1);
      check("w_lo_le_hi",   16'(le_hi),   16'h0);
      check("w_lo_bus_out", 16'(bus_out), 16'h23);
      cyc;
      check("w_we_n",    16'(we_n),    16'h0);
      check("w_oe_n",    16'(oe_n),    16'h1);
      check("w_bus_out", 16'(bus_out), 16'hC8);
      check("w_bus_oe",  16'(bus_oe),  16'h1);
      cyc;
      check("w_ready",  16'(ready), 16'h1);
      check("w_we_n_2", 16'(we_n),  16'h1);
      check("w_rdata_hold", 16'(rdata), 16'h5A);
      check("w_ext_latch",  {ext_hi, ext_lo}, 16'h0123);

      // 0x00FF then 0x0100: high byte changes across the wrap
      we = 1'b0; addr = 16'h00FF; bus_in = 8'h11;
      cyc;
      check("ff_le_hi",   16'(le_hi),   16'h1);
      check("ff_bus_out", 16'(bus_out), 16'h00);
      cyc; cyc; cyc;
      check("ff_ready", 16'(ready), 16'h1);
      check("ff_rdata", 16'(rdata), 16'h11);
      addr = 16'h0100; bus_in = 8'h22;
      cyc;
      check("wrap_le_hi",   16'(le_hi),   16'h1);
      check("wrap_bus_out", 16'(bus_out), 16'h01);
      cyc;
      check("wrap_lo_bus_out", 16'(bus_out), 16'h00);
      half;
      check("wrap_ext_latch", {ext_hi, ext_lo}, 16'h0100);
      cyc; cyc;
      check("wrap_ready", 16'(ready), 16'h1);
      check("wrap_rdata", 16'(rdata), 16'h22);

      // write aborted by reset during its strobe
      we = 1'b1; addr = 16'h4567; wdata = 8'h3C;
      cyc; cyc; cyc;
      check("ab_we_n_low", 16'(we_n), 16'h0);
      #2 rst = 1'b1; #1;
      check("ab_we_n_rst",   16'(we_n),    16'h1);
      check("ab_oe_n_rst",   16'(oe_n),    16'h1);
      check("ab_bus_out",    16'(bus_out), 16'h00);
      req = 1'b0; we = 1'b0;
      cyc;
      check("ab_no_ready", 16'(ready), 16'h0);
      rst = 1'b0; #1;
      check("ab_re_le_hi",   16'(le_hi),   16'h1);
      check("ab_re_bus_out", 16'(bus_out), 16'h00);
      cyc;
      check("ab_re_le_lo",   16'(le_lo),   16'h1);
      check("ab_re_lo_out",  16'(bus_out), 16'h00);
      check("ab_re_ready",   16'(ready),   16'h0);
      cyc;
      check("ab_re_oe_n", 16'(oe_n), 16'h0);
      cyc;
      check("ab_re_ready2", 16'(ready), 16'h1);
      check("ab_re_rdata",  16'(rdata), 16'h22);

      // two-wait-state read from 0x0000
      rst = 1'b1; req_2 = 1'b1; addr_2 = 16'h0000; bus_in_2 = 8'h00;
      cyc;
      rst = 1'b0; #1;
      check("ws_le_hi", 16'(le_hi_2), 16'h1);
      cyc;
      check("ws_le_lo", 16'(le_lo_2), 16'h1);
      cyc;
      check("ws_oe_n_1", 16'(oe_n_2), 16'h0);
      bus_in_2 = 8'h11;
      cyc;
      check("ws_oe_n_2",  16'(oe_n_2),  16'h0);
      check("ws_rdata_2", 16'(rdata_2), 16'h00);
      bus_in_2 = 8'h22;
      cyc;
      check("ws_oe_n_3",  16'(oe_n_2),  16'h0);
      check("ws_ready_3", 16'(ready_2), 16'h0);
      check("ws_rdata_3", 16'(rdata_2), 16'h00);
      bus_in_2 = 8'h33;
      cyc;
      check("ws_ready", 16'(ready_2), 16'h1);
      check("ws_rdata", 16'(rdata_2), 16'h33);
      check("ws_oe_n",  16'(oe_n_2),  16'h1);
      req_2 = 1'b0;
      cyc;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
